fmul_seq_ctrl: RTL and testbench
================================

FMUL_SEQ_CTRL -- requirements
Module: fmul_seq_ctrl

Interface
REQ-001 The block SHALL have exactly one clock, `clk`, and a synchronous, active-high reset, `rst`.
REQ-002 Ports SHALL be, in order:
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous reset, active-high.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: block can accept an operand pair.
- `op_a` in 32: IEEE-754 single-precision operand A.
- `op_b` in 32: IEEE-754 single-precision operand B.
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `result` out 32: IEEE-754 single-precision product.
- `flags` out 4: {invalid, overflow, underflow, inexact}.
REQ-003 The block SHALL have no parameters; all widths come from `fpu_pkg`.

Function
REQ-004 The FSM SHALL have the states IDLE, MUL, NORM, RND and DONE.
REQ-005 `in_ready` SHALL be 1 only in IDLE; an accept is `in_valid & in_ready` at a rising edge, and `op_a`/`op_b` SHALL be latched at that edge.
REQ-006 Accept SHALL take IDLE->MUL if both operands are finite and nonzero, and IDLE->DONE otherwise.
REQ-007 MUL SHALL register the 48-bit product of the two {hidden, mantissa} fields and the 10-bit signed exponent ea+eb-127.
- The sign SHALL be sa^sb.
- A subnormal operand SHALL use hidden=0 and exponent 1.
REQ-008 NORM SHALL drive product[47:22] into the normalizer.
- It SHALL register `mant24` = bits [24:1] of the normalized output.
- It SHALL register `guard` = normalized output bit [0].
- `sticky` SHALL be the OR of all product bits not forwarded to the normalized output.
- The exponent SHALL be updated as exp + ovf - SHL.
REQ-009 RND SHALL perform round-to-nearest-even on `mant24`, `guard` and `sticky`.
- A mantissa carry-out SHALL increment the exponent.
- exp >= 255 SHALL give ±Inf with overflow=1 and inexact=1.
- inexact SHALL be guard|sticky.
REQ-010 Special cases (IDLE->DONE path) SHALL resolve as follows:
- NaN operand, or Inf×0: result 0x7FC00000, invalid=1.
- Inf×finite-nonzero: ±Inf.
- Any zero otherwise: ±0.
- All other flags SHALL be 0.
REQ-011 DONE SHALL hold `out_valid`=1 with `result` and `flags` stable until `out_ready`=1, then go to IDLE.
- The next accept SHALL occur no earlier than the following cycle.
REQ-012 Latency SHALL be 4 cycles from accept to `out_valid` on the normal path and 1 cycle on the special path.
- Throughput SHALL be one operation per 5 cycles when `out_ready` is held at 1.
REQ-013 `out_ready` outside DONE and `in_valid` outside IDLE SHALL be ignored.

Reset
REQ-014 When `rst`=1 at a clock edge:
- The state SHALL become IDLE.
- `out_valid`=0, `in_ready`=1 in the following cycle, `result`=0, `flags`=0.
- All internal registers SHALL be 0.
REQ-015 A reset in any state, including mid-operation or in DONE with `out_valid`=1, SHALL discard the operation; no result is emitted.

Configuration
REQ-016 Macro `FMUL_SUBNORM_EN` SHALL select subnormal handling as follows.
- Defined, inputs: subnormal inputs are processed per REQ-007.
- Defined, NORM: uses `mant24` = (product << SHL)[46:23] when SHL>0.
- Defined, RND: when exp <= 0 it right-shifts the mantissa by 1-exp into the sticky bit and emits a subnormal or zero, with underflow=1 if the result is tiny and inexact.
- Undefined: subnormal inputs are treated as ±0.
- Undefined: results with exp <= 0 flush to signed zero with underflow=1 and inexact=1.

Structure
REQ-017 Package `fpu_pkg` SHALL hold:
- Widths EXP_W=8, MAN_W=23, PROD_W=48.
- BIAS=127.
- The canonical QNaN 0x7FC00000.
- The state encoding.
- The flag bit positions.
REQ-018 The existing leading-zero normalization unit SHALL be instantiated once as the only sub-module, fed from the MUL-stage product register.

Verification
REQ-019 Accept 0x3FC00000 × 0x40000000 -> `result` 0x40400000, flags 0, `out_valid` exactly 4 cycles after accept.
REQ-020 Accept 0x7F800000 × 0x00000000 -> `result` 0x7FC00000, invalid=1, `out_valid` 1 cycle after accept.
REQ-021 Accept 0x7F7FFFFF × 0x40000000 -> `result` 0x7F800000, overflow=1, inexact=1.
REQ-022 Hold `out_ready`=0 for 3 cycles in DONE -> `result` stable, `in_ready`=0, `in_valid` pulses ignored; `out_ready`=1 -> IDLE next cycle.
REQ-023 Assert `rst` in NORM -> next cycle IDLE, `out_valid`=0, `in_ready`=1, no result; a following 0x3F800000 × 0x3F800000 returns 0x3F800000.
REQ-024 Accept 0x00000001 × 0x4B000000 -> 0x00800000, flags 0 with `FMUL_SUBNORM_EN` defined; 0x00000000 with the macro undefined.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared widths, constants, FSM encoding and flag positions for the
// sequential single-precision multiplier.
package fpu_pkg;

  localparam int unsigned EXP_W  = 8;
  localparam int unsigned MAN_W  = 23;
  localparam int unsigned PROD_W = 48;
  localparam int unsigned FP_W   = 1 + EXP_W + MAN_W;
  localparam int unsigned SIG_W  = MAN_W + 1;
  localparam int unsigned XEXP_W = 10;
  localparam int unsigned FLAG_W = 4;

  localparam int BIAS = 127;

  localparam logic [FP_W-1:0] QNAN = 32'h7FC0_0000;

  // Flag vector is {invalid, overflow, underflow, inexact}
  localparam int unsigned FLAG_NV = 3;
  localparam int unsigned FLAG_OF = 2;
  localparam int unsigned FLAG_UF = 1;
  localparam int unsigned FLAG_NX = 0;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL  = 3'd1,
    ST_NORM = 3'd2,
    ST_RND  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Leading-zero count of a 25-bit window; returns 25 for an all-zero input.
  function automatic logic [4:0] lzc25(input logic [24:0] x);
    logic [4:0] n;
    logic       hit;
    n   = '0;
    hit = 1'b0;
    for (int unsigned i = 0; i < 25; i++) begin
      if (!hit) begin
        if (x[24-i]) hit = 1'b1;
        else         n   = n + 5'd1;
      end
    end
    return n;
  endfunction

endpackage

// File: rtl/fmul_seq_ctrl_norm.sv
// Leading-zero normalization unit: takes the top 26 bits of the mantissa
// product and returns a 25-bit normalized window (24-bit mantissa + guard),
// the product-overflow indication and the left-shift amount.
module fmul_seq_ctrl_norm
  import fpu_pkg::*;
(
  input  logic [25:0] win,
  output logic [24:0] norm,
  output logic        ovf,
  output logic [4:0]  shl
);

  // Overflowed products drop one bit on the right; otherwise shift left.
  always_comb begin
    ovf  = win[25];
    shl  = ovf ? 5'd0 : lzc25(win[24:0]);
    norm = ovf ? win[25:1] : (win[24:0] << shl);
  end

endmodule

// File: rtl/fmul_seq_ctrl.sv
// Sequential IEEE-754 single-precision multiplier controller.
// FSM IDLE -> MUL -> NORM -> RND -> DONE, special operands go IDLE -> DONE.
// Optional FMUL_SUBNORM_EN: process subnormal inputs/outputs; without it,
// subnormal inputs act as zero and tiny results flush to signed zero.
module fmul_seq_ctrl
  import fpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [FP_W-1:0]   op_a,
  input  logic [FP_W-1:0]   op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FP_W-1:0]   result,
  output logic [FLAG_W-1:0] flags
);

  state_t                    state;
  logic [FP_W-1:0]           op_a_q, op_b_q;
  logic                      sign_q;
  logic signed [XEXP_W-1:0]  exp_q;
  logic [PROD_W-1:0]         prod_q;
  logic [SIG_W-1:0]          mant24_q;
  logic                      guard_q, sticky_q;

  // ---------------- special-operand decode on the input ports
  logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sp_hit;
  logic [FP_W-1:0]   sp_res;
  logic [FLAG_W-1:0] sp_flg;

  // Classify operands at accept time and resolve the special result.
  always_comb begin
    a_nan = (&op_a[30:23]) &  (|op_a[22:0]);
    b_nan = (&op_b[30:23]) &  (|op_b[22:0]);
    a_inf = (&op_a[30:23]) & ~(|op_a[22:0]);
    b_inf = (&op_b[30:23]) & ~(|op_b[22:0]);
`ifdef FMUL_SUBNORM_EN
    a_zero = (op_a[30:0] == '0);
    b_zero = (op_b[30:0] == '0);
`else
    a_zero = (op_a[30:23] == '0);
    b_zero = (op_b[30:23] == '0);
`endif
    sp_hit = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
    sp_flg = '0;
    if (a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf)) begin
      sp_res          = QNAN;
      sp_flg[FLAG_NV] = 1'b1;
    end else if (a_inf | b_inf) begin
      sp_res = {op_a[31] ^ op_b[31], 8'hFF, 23'd0};
    end else begin
      sp_res = {op_a[31] ^ op_b[31], 31'd0};
    end
  end

  // ---------------- MUL stage datapath
  logic                 hid_a, hid_b;
  logic [EXP_W-1:0]     ea_eff, eb_eff;
  logic [PROD_W-1:0]    m_prod;
  logic [XEXP_W-1:0]    m_exp;

  // Subnormal operands carry hidden=0 with an effective exponent of 1.
  always_comb begin
    hid_a  = |op_a_q[30:23];
    hid_b  = |op_b_q[30:23];
    ea_eff = hid_a ? op_a_q[30:23] : 8'd1;
    eb_eff = hid_b ? op_b_q[30:23] : 8'd1;
    m_prod = PROD_W'({hid_a, op_a_q[22:0]}) * PROD_W'({hid_b, op_b_q[22:0]});
    m_exp  = {2'b00, ea_eff} + {2'b00, eb_eff} - 10'(BIAS);
  end

  // ---------------- NORM stage datapath
  logic [24:0]              norm_out;
  logic                     norm_ovf;
  logic [4:0]               norm_shl;
  logic [SIG_W-1:0]         n_mant;
  logic                     n_guard, n_sticky;
  logic signed [XEXP_W-1:0] n_exp;
`ifdef FMUL_SUBNORM_EN
  logic [PROD_W-1:0]        n_shifted;
`endif

  fmul_seq_ctrl_norm u_norm (
    .win  (prod_q[47:22]),
    .norm (norm_out),
    .ovf  (norm_ovf),
    .shl  (norm_shl)
  );

  // Split the normalized window into mantissa, guard and sticky.
  always_comb begin
    n_mant   = norm_out[24:1];
    n_guard  = norm_out[0];
    n_sticky = (norm_ovf & prod_q[22]) | (|prod_q[21:0]);
`ifdef FMUL_SUBNORM_EN
    // A left shift pulls bits from below the 26-bit window, so re-slice
    // the full shifted product rather than trusting the window alone.
    n_shifted = prod_q << norm_shl;
    if (norm_shl != '0) begin
      n_mant   = n_shifted[46:23];
      n_guard  = n_shifted[22];
      n_sticky = |n_shifted[21:0];
    end
`endif
    n_exp = exp_q + 10'(norm_ovf) - 10'(norm_shl);
  end

  // ---------------- RND stage datapath
  logic                     round_up;
  logic [24:0]              r_sum;
  logic [22:0]              r_frac;
  logic signed [XEXP_W-1:0] r_exp;
  logic [FP_W-1:0]          r_res;
  logic [FLAG_W-1:0]        r_flg;
`ifdef FMUL_SUBNORM_EN
  logic [XEXP_W-1:0]        d_sh;
  logic [24:0]              d_v, d_vs, d_lost;
  logic [SIG_W-1:0]         d_mant, d_sum;
  logic                     d_guard, d_sticky, d_ru;
`endif

  // Round-to-nearest-even, overflow to Inf, tiny results per build option.
  always_comb begin
    round_up = guard_q & (sticky_q | mant24_q[0]);
    r_sum    = {1'b0, mant24_q} + 25'(round_up);
    r_frac   = r_sum[24] ? r_sum[23:1] : r_sum[22:0];
    r_exp    = exp_q + 10'(r_sum[24]);
    r_res    = '0;
    r_flg    = '0;
`ifdef FMUL_SUBNORM_EN
    d_sh     = 10'sd1 - exp_q;
    d_v      = {mant24_q, guard_q};
    if (d_sh >= 10'd25) begin
      d_vs   = '0;
      d_lost = d_v;
    end else begin
      d_vs   = d_v >> d_sh[4:0];
      d_lost = d_v & ((25'd1 << d_sh[4:0]) - 25'd1);
    end
    d_mant   = d_vs[24:1];
    d_guard  = d_vs[0];
    d_sticky = sticky_q | (|d_lost);
    d_ru     = d_guard & (d_sticky | d_mant[0]);
    d_sum    = d_mant + 24'(d_ru);
`endif
    if (exp_q <= 10'sd0) begin
`ifdef FMUL_SUBNORM_EN
      // d_sum[23] set means rounding carried into the smallest normal.
      r_res          = {sign_q, 7'd0, d_sum};
      r_flg[FLAG_NX] = d_guard | d_sticky;
      r_flg[FLAG_UF] = d_guard | d_sticky;
`else
      r_res          = {sign_q, 31'd0};
      r_flg[FLAG_UF] = 1'b1;
      r_flg[FLAG_NX] = 1'b1;
`endif
    end else if (r_exp >= 10'sd255) begin
      r_res          = {sign_q, 8'hFF, 23'd0};
      r_flg[FLAG_OF] = 1'b1;
      r_flg[FLAG_NX] = 1'b1;
    end else begin
      r_res          = {sign_q, r_exp[7:0], r_frac};
      r_flg[FLAG_NX] = guard_q | sticky_q;
    end
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      flags     <= '0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      sign_q    <= 1'b0;
      exp_q     <= '0;
      prod_q    <= '0;
      mant24_q  <= '0;
      guard_q   <= 1'b0;
      sticky_q  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            op_a_q   <= op_a;
            op_b_q   <= op_b;
            in_ready <= 1'b0;
            if (sp_hit) begin
              result    <= sp_res;
              flags     <= sp_flg;
              out_valid <= 1'b1;
              state     <= ST_DONE;
            end else begin
              state <= ST_MUL;
            end
          end
        end
        ST_MUL: begin
          sign_q <= op_a_q[31] ^ op_b_q[31];
          exp_q  <= m_exp;
          prod_q <= m_prod;
          state  <= ST_NORM;
        end
        ST_NORM: begin
          mant24_q <= n_mant;
          guard_q  <= n_guard;
          sticky_q <= n_sticky;
          exp_q    <= n_exp;
          state    <= ST_RND;
        end
        ST_RND: begin
          result    <= r_res;
          flags     <= r_flg;
          out_valid <= 1'b1;
          state     <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fmul_seq_ctrl.sv
// Directed self-checking bench for fmul_seq_ctrl (honours FMUL_SUBNORM_EN).
module tb_fmul_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] op_a, op_b, result;
  logic [3:0]  flags;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fmul_seq_ctrl dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One transaction: accept, measure latency, compare, drain.
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] res, input logic [3:0] flg, input int lat_exp);
    int lat;
    @(negedge clk);
    check({tag, ":in_ready"}, 32'(in_ready), 32'd1);
    op_a = a; op_b = b; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    check({tag, ":latency"}, 32'(lat), 32'(lat_exp));
    check({tag, ":result"}, result, res);
    check({tag, ":flags"}, 32'(flags), 32'(flg));
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, ":drain_ov"}, 32'(out_valid), 32'd0);
    check({tag, ":drain_ir"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int acc0, acc1, cyc, w;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset:out_valid", 32'(out_valid), 32'd0);
    check("reset:in_ready",  32'(in_ready),  32'd1);
    check("reset:result",    result,         32'd0);
    check("reset:flags",     32'(flags),     32'd0);

    run_op("mul_1p5x2",   32'h3FC00000, 32'h40000000, 32'h40400000, 4'b0000, 4);
    run_op("inf_x_zero",  32'h7F800000, 32'h00000000, 32'h7FC00000, 4'b1000, 1);
    run_op("overflow",    32'h7F7FFFFF, 32'h40000000, 32'h7F800000, 4'b0101, 4);
    run_op("one_x_one",   32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 4);
    run_op("neg",         32'hBF800000, 32'h40000000, 32'hC0000000, 4'b0000, 4);
    run_op("ninf_x_one",  32'hFF800000, 32'h3F800000, 32'hFF800000, 4'b0000, 1);
    run_op("nzero_x_one", 32'h80000000, 32'h3F800000, 32'h80000000, 4'b0000, 1);
    run_op("nan_in",      32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000, 1);
    run_op("inexact_dn",  32'h3F800001, 32'h3F800001, 32'h3F800002, 4'b0001, 4);
    run_op("tie_even_up", 32'h3F800001, 32'h3FC00000, 32'h3FC00002, 4'b0001, 4);
    run_op("prod_ovf",    32'h3FC00000, 32'h3FC00000, 32'h40100000, 4'b0000, 4);
    run_op("deep_tiny",   32'h00800000, 32'h00800000, 32'h00000000, 4'b0011, 4);
`ifdef FMUL_SUBNORM_EN
    run_op("sub_out",     32'h00800000, 32'h3F000000, 32'h00400000, 4'b0000, 4);
    run_op("sub_in",      32'h00000001, 32'h4B000000, 32'h00800000, 4'b0000, 4);
`else
    run_op("sub_out",     32'h00800000, 32'h3F000000, 32'h00000000, 4'b0011, 4);
    run_op("sub_in",      32'h00000001, 32'h4B000000, 32'h00000000, 4'b0000, 1);
`endif

    // Backpressure in DONE: result held, in_valid ignored.
    @(negedge clk);
    op_a = 32'h3FC00000; op_b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    w = 0;
    while (w < 20 && !out_valid) begin @(negedge clk); w++; end
    check("hold:reached", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      op_a = 32'h3F800000; op_b = 32'h3F800000; in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      @(negedge clk);
      check("hold:result",    result,          32'h40400000);
      check("hold:in_ready",  32'(in_ready),   32'd0);
      check("hold:out_valid", 32'(out_valid),  32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("hold:rel_in_ready",  32'(in_ready),  32'd1);
    check("hold:rel_out_valid", 32'(out_valid), 32'd0);
    repeat (3) @(negedge clk);
    check("hold:no_ghost", 32'(out_valid), 32'd0);

    // Reset while in NORM discards the operation.
    @(negedge clk);
    op_a = 32'h3FC00000; op_b = 32'h40000000; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_norm:out_valid", 32'(out_valid), 32'd0);
    check("rst_norm:in_ready",  32'(in_ready),  32'd1);
    check("rst_norm:result",    result,         32'd0);
    repeat (6) @(negedge clk);
    check("rst_norm:no_result", 32'(out_valid), 32'd0);
    run_op("after_rst", 32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 4);

    // Throughput with out_ready held high: accepts 5 cycles apart.
    acc0 = -1; acc1 = -1;
    out_ready = 1'b1;
    op_a = 32'h3F800000; op_b = 32'h3F800000;
    for (cyc = 0; cyc < 14; cyc++) begin
      @(negedge clk);
      in_valid = 1'b1;
      if (in_ready) begin
        if (acc0 < 0) acc0 = cyc;
        else if (acc1 < 0) acc1 = cyc;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    out_ready = 1'b0;
    check("thruput:gap", 32'(acc1 - acc0), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
